// File: rtl/snake_pkg.sv
// Shared types and constants for the snake body controller: direction and
// master-state codes, default grid size, cell coordinate widths and colours.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    M_IDLE = 2'b00,
    M_PLAY = 2'b01,
    M_WIN  = 2'b10,
    M_FAIL = 2'b11
  } mstate_t;

  localparam int GRID_X_DEF = 160;
  localparam int GRID_Y_DEF = 120;

  localparam int CX_W = 8;
  localparam int CY_W = 7;
  localparam int LEN_W = 6;

  localparam logic [11:0] COL_HEAD   = 12'h0F0;
  localparam logic [11:0] COL_BODY   = 12'hFF0;
  localparam logic [11:0] COL_TARGET = 12'hF00;
  localparam logic [11:0] COL_BG     = 12'h00F;

  // Opposite directions differ only in bit 1 with this encoding.
  function automatic dir_t dir_opposite(dir_t d);
    return dir_t'(d ^ 2'b10);
  endfunction

endpackage

// File: rtl/snake_move_tick.sv
// Move-rate timer: counts 0..MOVE_PERIOD-1 while enabled and emits a
// one-cycle tick on the terminal count. Clear forces the count back to 0.
module snake_move_tick #(
  parameter int MOVE_PERIOD = 12_500_000
) (
  input  logic CLK,
  input  logic RESETN,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
  localparam logic [CW-1:0] TC = CW'(MOVE_PERIOD - 1);

  logic [CW-1:0] r_cnt;
  logic          w_tc;

  assign w_tc   = (r_cnt == TC);
  assign o_tick = i_en && w_tc && !i_clr;

  // Period counter; holds its value when disabled so WIN/FAIL freeze it.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_tc ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/snake_body_control.sv
// Snake body controller: segment shift register, direction handling,
// growth/collision detection and per-pixel colour lookup.
// Build option: define SNAKE_WRAP_EN to wrap the head around the grid edges;
// without it, leaving the grid is treated as a collision and the body holds.
module snake_body_control
  import snake_pkg::*;
#(
  parameter int MAX_LENGTH  = 32,
  parameter int INIT_LENGTH = 4,
  parameter int GRID_X      = GRID_X_DEF,
  parameter int GRID_Y      = GRID_Y_DEF,
  parameter int CELL_SHIFT  = 2,
  parameter int MOVE_PERIOD = 12_500_000
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic [1:0]  M_STATE,
  input  logic [1:0]  NAV_STATE,
  input  logic [9:0]  ADDR_H,
  input  logic [8:0]  ADDR_V,
  input  logic [7:0]  TARGET_H,
  input  logic [6:0]  TARGET_V,
  output logic [11:0] COLOUR_OUT,
  output logic        TARGET_REACHED,
  output logic        SELF_COLLIDE,
  output logic [5:0]  LENGTH
);

`ifdef SNAKE_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  localparam int START_X = GRID_X / 2;
  localparam int START_Y = GRID_Y / 2;

  logic [CX_W-1:0]  r_seg_x [MAX_LENGTH];
  logic [CY_W-1:0]  r_seg_y [MAX_LENGTH];
  logic [LEN_W-1:0] r_length;
  dir_t             r_dir;
  dir_t             r_last_dir;
  logic             r_collide;
  logic             r_target_reached;
  logic [11:0]      r_colour;

  mstate_t          w_mstate;
  logic             w_idle;
  logic             w_play;
  logic             w_tick;
  logic             w_move;
  dir_t             w_nav;
  dir_t             w_dir_eff;
  logic [CX_W-1:0]  w_nx;
  logic [CY_W-1:0]  w_ny;
  logic             w_off_grid;
  logic             w_self_hit;
  logic             w_fail;
  logic             w_target_hit;
  logic [9:0]       w_cx;
  logic [8:0]       w_cy;
  logic             w_in_range;
  logic             w_is_head;
  logic             w_is_body;
  logic             w_is_target;
  logic [11:0]      w_colour_nx;

  assign w_mstate = mstate_t'(M_STATE);
  assign w_idle   = (w_mstate == M_IDLE);
  assign w_play   = (w_mstate == M_PLAY);

  snake_move_tick #(
    .MOVE_PERIOD(MOVE_PERIOD)
  ) u_tick (
    .CLK    (CLK),
    .RESETN (RESETN),
    .i_en   (w_play),
    .i_clr  (w_idle),
    .o_tick (w_tick)
  );

  // A reversal against the last executed move is dropped; otherwise NAV wins.
  assign w_nav     = dir_t'(NAV_STATE);
  assign w_dir_eff = (w_nav == dir_opposite(r_last_dir)) ? r_dir : w_nav;

  // Candidate head position one cell along the effective direction.
  always_comb begin
    w_nx       = r_seg_x[0];
    w_ny       = r_seg_y[0];
    w_off_grid = 1'b0;
    case (w_dir_eff)
      DIR_UP: begin
        if (r_seg_y[0] == '0) begin
          w_off_grid = 1'b1;
          w_ny       = CY_W'(GRID_Y - 1);
        end else begin
          w_ny = r_seg_y[0] - 1'b1;
        end
      end
      DIR_RIGHT: begin
        if (r_seg_x[0] == CX_W'(GRID_X - 1)) begin
          w_off_grid = 1'b1;
          w_nx       = '0;
        end else begin
          w_nx = r_seg_x[0] + 1'b1;
        end
      end
      DIR_DOWN: begin
        if (r_seg_y[0] == CY_W'(GRID_Y - 1)) begin
          w_off_grid = 1'b1;
          w_ny       = '0;
        end else begin
          w_ny = r_seg_y[0] + 1'b1;
        end
      end
      default: begin
        if (r_seg_x[0] == '0) begin
          w_off_grid = 1'b1;
          w_nx       = CX_W'(GRID_X - 1);
        end else begin
          w_nx = r_seg_x[0] - 1'b1;
        end
      end
    endcase
  end

  // Self-hit against seg[1..LENGTH-2]; the tail cell vacates on the same move.
  always_comb begin
    w_self_hit = 1'b0;
    for (int i = 1; i < MAX_LENGTH; i++) begin
      if ((i + 2 <= int'(r_length)) && (r_seg_x[i] == w_nx) && (r_seg_y[i] == w_ny))
        w_self_hit = 1'b1;
    end
  end

  assign w_fail       = w_self_hit || (w_off_grid && !WRAP_EN);
  assign w_move       = w_tick && !r_collide;
  assign w_target_hit = (w_nx == TARGET_H) && (w_ny == TARGET_V);

  // Segment shift register: re-seeded in IDLE, shifted on a clean move.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      for (int i = 0; i < MAX_LENGTH; i++) begin
        r_seg_x[i] <= CX_W'(START_X - i);
        r_seg_y[i] <= CY_W'(START_Y);
      end
    end else if (w_idle) begin
      for (int i = 0; i < MAX_LENGTH; i++) begin
        r_seg_x[i] <= CX_W'(START_X - i);
        r_seg_y[i] <= CY_W'(START_Y);
      end
    end else if (w_move && !w_fail) begin
      for (int i = MAX_LENGTH - 1; i > 0; i--) begin
        r_seg_x[i] <= r_seg_x[i-1];
        r_seg_y[i] <= r_seg_y[i-1];
      end
      r_seg_x[0] <= w_nx;
      r_seg_y[0] <= w_ny;
    end
  end

  // Direction, length, sticky collision flag and target pulse.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_dir            <= DIR_RIGHT;
      r_last_dir       <= DIR_RIGHT;
      r_length         <= LEN_W'(INIT_LENGTH);
      r_collide        <= 1'b0;
      r_target_reached <= 1'b0;
    end else begin
      r_target_reached <= 1'b0;
      if (w_idle) begin
        r_dir      <= DIR_RIGHT;
        r_last_dir <= DIR_RIGHT;
        r_length   <= LEN_W'(INIT_LENGTH);
        r_collide  <= 1'b0;
      end else if (w_play) begin
        r_dir <= w_dir_eff;
        if (w_move) begin
          if (w_fail) begin
            r_collide <= 1'b1;
          end else begin
            r_last_dir <= w_dir_eff;
            if (w_target_hit) begin
              r_target_reached <= 1'b1;
              if (r_length < LEN_W'(MAX_LENGTH))
                r_length <= r_length + 1'b1;
            end
          end
        end
      end
    end
  end

  // Pixel-to-cell lookup with head > body > target > background priority.
  always_comb begin
    w_cx        = ADDR_H >> CELL_SHIFT;
    w_cy        = ADDR_V >> CELL_SHIFT;
    w_in_range  = (ADDR_H < 10'(GRID_X << CELL_SHIFT)) && (ADDR_V < 9'(GRID_Y << CELL_SHIFT));
    w_is_head   = (w_cx == 10'(r_seg_x[0])) && (w_cy == 9'(r_seg_y[0]));
    w_is_target = (w_cx == 10'(TARGET_H)) && (w_cy == 9'(TARGET_V));
    w_is_body   = 1'b0;
    for (int i = 1; i < MAX_LENGTH; i++) begin
      if ((i < int'(r_length)) && (w_cx == 10'(r_seg_x[i])) && (w_cy == 9'(r_seg_y[i])))
        w_is_body = 1'b1;
    end
    w_colour_nx = COL_BG;
    if (w_in_range) begin
      if (w_is_head)        w_colour_nx = COL_HEAD;
      else if (w_is_body)   w_colour_nx = COL_BODY;
      else if (w_is_target) w_colour_nx = COL_TARGET;
    end
  end

  // Colour register; blanked while the game sits in IDLE.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN)     r_colour <= '0;
    else if (w_idle) r_colour <= '0;
    else             r_colour <= w_colour_nx;
  end

  assign COLOUR_OUT     = r_colour;
  assign TARGET_REACHED = r_target_reached;
  assign SELF_COLLIDE   = r_collide;
  assign LENGTH         = r_length;

endmodule

// File: tb/tb_snake_body_control.sv
module tb_snake_body_control;

  logic        CLK = 1'b0;
  logic        RESETN = 1'b1;
  logic [1:0]  M_STATE = 2'b00;
  logic [1:0]  NAV_STATE = 2'b01;
  logic [9:0]  ADDR_H = '0;
  logic [8:0]  ADDR_V = '0;
  logic [7:0]  TARGET_H = 8'd10;
  logic [6:0]  TARGET_V = 7'd100;
  wire  [11:0] COLOUR_OUT;
  wire         TARGET_REACHED;
  wire         SELF_COLLIDE;
  wire  [5:0]  LENGTH;

  int n_tests = 0;
  int n_fail  = 0;
  logic [11:0] col;

  snake_body_control #(
    .MOVE_PERIOD(4)
  ) dut (
    .CLK            (CLK),
    .RESETN         (RESETN),
    .M_STATE        (M_STATE),
    .NAV_STATE      (NAV_STATE),
    .ADDR_H         (ADDR_H),
    .ADDR_V         (ADDR_V),
    .TARGET_H       (TARGET_H),
    .TARGET_V       (TARGET_V),
    .COLOUR_OUT     (COLOUR_OUT),
    .TARGET_REACHED (TARGET_REACHED),
    .SELF_COLLIDE   (SELF_COLLIDE),
    .LENGTH         (LENGTH)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic moves(input int n);
    cycles(4 * n);
  endtask

  task automatic probe(input int x, input int y, output logic [11:0] c);
    ADDR_H = 10'(x * 4 + 1);
    ADDR_V = 9'(y * 4 + 2);
    @(negedge CLK);
    c = COLOUR_OUT;
  endtask

  task automatic go_idle();
    M_STATE = 2'b00;
    cycles(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset values
    #1 RESETN = 1'b0;
    #1;
    check("rst_colour", COLOUR_OUT, 12'h000);
    check("rst_tr", TARGET_REACHED, 1'b0);
    check("rst_sc", SELF_COLLIDE, 1'b0);
    check("rst_len", LENGTH, 6'd4);
    cycles(2);
    RESETN = 1'b1;
    cycles(1);

    // Three moves right
    M_STATE = 2'b01; NAV_STATE = 2'b01;
    moves(3);
    M_STATE = 2'b10;
    probe(83, 60, col); check("t1_head", col, 12'h0F0);
    probe(80, 60, col); check("t1_seg3", col, 12'hFF0);
    probe(79, 60, col); check("t1_vacated", col, 12'h00F);
    probe(10, 100, col); check("t1_target", col, 12'hF00);
    check("t1_len", LENGTH, 6'd4);

    // Reversal ignored, then turn up
    M_STATE = 2'b01; NAV_STATE = 2'b11;
    moves(1);
    M_STATE = 2'b10;
    probe(84, 60, col); check("t2_rev_ignored", col, 12'h0F0);
    M_STATE = 2'b01; NAV_STATE = 2'b00;
    moves(1);
    M_STATE = 2'b10;
    probe(84, 59, col); check("t2_up_head", col, 12'h0F0);
    probe(84, 60, col); check("t2_up_body", col, 12'hFF0);

    // Target hits and length saturation
    TARGET_H = 8'd84; TARGET_V = 7'd58;
    M_STATE = 2'b01;
    cycles(3); check("t3_tr_pre", TARGET_REACHED, 1'b0);
    cycles(1); check("t3_tr_hit", TARGET_REACHED, 1'b1);
    check("t3_len5", LENGTH, 6'd5);
    for (int k = 1; k <= 30; k++) begin
      TARGET_V = 7'(58 - k);
      cycles(1); check("t3_tr_low", TARGET_REACHED, 1'b0);
      cycles(3); check("t3_tr_rep", TARGET_REACHED, 1'b1);
      check("t3_len_rep", LENGTH, (5 + k > 32) ? 32 : 5 + k);
    end
    M_STATE = 2'b10;
    cycles(1); check("t3_tr_end", TARGET_REACHED, 1'b0);
    probe(84, 28, col); check("t3_head_over_target", col, 12'h0F0);
    probe(84, 29, col); check("t3_body", col, 12'hFF0);
    TARGET_H = 8'd5; TARGET_V = 7'd5;
    probe(5, 5, col); check("t3_target_only", col, 12'hF00);

    // Tail cell is exempt from collision
    go_idle();
    check("t5_idle_len", LENGTH, 6'd4);
    TARGET_H = 8'd10; TARGET_V = 7'd100;
    M_STATE = 2'b01;
    NAV_STATE = 2'b01; moves(1);
    NAV_STATE = 2'b00; moves(1);
    NAV_STATE = 2'b11; moves(1);
    NAV_STATE = 2'b10; moves(1);
    check("t5_tail_exempt", SELF_COLLIDE, 1'b0);
    M_STATE = 2'b10;
    probe(80, 60, col); check("t5_tail_head", col, 12'h0F0);

    // Length 5 U-turn hits seg[3]
    go_idle();
    TARGET_H = 8'd81; TARGET_V = 7'd60;
    NAV_STATE = 2'b01; M_STATE = 2'b01;
    moves(1);
    check("t5_len5", LENGTH, 6'd5);
    TARGET_H = 8'd10; TARGET_V = 7'd100;
    NAV_STATE = 2'b00; moves(1);
    NAV_STATE = 2'b11; moves(1);
    NAV_STATE = 2'b10;
    cycles(3); check("t5_sc_pre", SELF_COLLIDE, 1'b0);
    cycles(1); check("t5_sc_set", SELF_COLLIDE, 1'b1);
    check("t5_sc_len", LENGTH, 6'd5);
    cycles(8); check("t5_sc_hold", SELF_COLLIDE, 1'b1);
    M_STATE = 2'b00;
    cycles(1); check("t5_sc_clear", SELF_COLLIDE, 1'b0);
    check("t5_len_reinit", LENGTH, 6'd4);

    // Left edge behaviour
    go_idle();
    M_STATE = 2'b01;
    NAV_STATE = 2'b00; moves(1);
    NAV_STATE = 2'b11; moves(80);
    NAV_STATE = 2'b10; moves(1);
    check("t4_pre_sc", SELF_COLLIDE, 1'b0);
    NAV_STATE = 2'b11; moves(1);
    M_STATE = 2'b10;
    cycles(1);
`ifdef SNAKE_WRAP_EN
    check("t4_wrap_sc", SELF_COLLIDE, 1'b0);
    probe(159, 60, col); check("t4_wrap_head", col, 12'h0F0);
    probe(0, 60, col); check("t4_wrap_body", col, 12'hFF0);
`else
    check("t4_edge_sc", SELF_COLLIDE, 1'b1);
    probe(0, 60, col); check("t4_edge_head", col, 12'h0F0);
    probe(159, 60, col); check("t4_edge_bg", col, 12'h00F);
`endif

    // Rendering and reset mid-count
    go_idle();
    ADDR_H = 10'd320; ADDR_V = 9'd240;
    cycles(1); check("t6_idle_colour", COLOUR_OUT, 12'h000);
    M_STATE = 2'b10;
    cycles(1); check("t6_head_px", COLOUR_OUT, 12'h0F0);
    ADDR_H = 10'd0; ADDR_V = 9'd0;
    cycles(1); check("t6_origin_bg", COLOUR_OUT, 12'h00F);
    ADDR_H = 10'd643; ADDR_V = 9'd240;
    cycles(1); check("t6_h_beyond", COLOUR_OUT, 12'h00F);
    ADDR_H = 10'd320; ADDR_V = 9'd480;
    cycles(1); check("t6_v_beyond", COLOUR_OUT, 12'h00F);
    ADDR_H = 10'd320; ADDR_V = 9'd240;
    NAV_STATE = 2'b01; M_STATE = 2'b01;
    cycles(2); check("t6_pre_rst_colour", COLOUR_OUT, 12'h0F0);
    #2 RESETN = 1'b0;
    #1;
    check("t6_rst_colour", COLOUR_OUT, 12'h000);
    check("t6_rst_tr", TARGET_REACHED, 1'b0);
    check("t6_rst_sc", SELF_COLLIDE, 1'b0);
    check("t6_rst_len", LENGTH, 6'd4);
    @(negedge CLK);
    RESETN = 1'b1;
    cycles(3);
    M_STATE = 2'b10;
    probe(80, 60, col); check("t6_no_partial", col, 12'h0F0);
    M_STATE = 2'b01;
    cycles(1);
    M_STATE = 2'b10;
    probe(81, 60, col); check("t6_first_move", col, 12'h0F0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
